uart_tx_arbiter: RTL and testbench

Shares one UART serial transmit line between `NUM_REQ` byte-stream requesters. Arbitration is round-robin. The winner's byte is framed as 8N1, LSB first, one bit per `uart_tick` pulse from the baud generator. The block sits between on-chip byte producers (boot monitor, debug port, CPU MMIO) and the board TX pin. The baud generator, with its 1-cycle `uart_tick` strobe, stays outside this block.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: serializer states, data width,
// line idle level and the parity helper.
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request at or after rr_ptr,
// searching upward and wrapping, reported as a one-hot grant plus its index.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               req_any
);

    logic [NUM_REQ-1:0] rot_s;
    logic [ID_W-1:0]    off_s;
    logic [ID_W:0]      sum_s;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        rot_s = NUM_REQ'({req, req} >> rr_ptr);
        off_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? ID_W'(k) : off_s;
        end
        sum_s     = {1'b0, rr_ptr} + {1'b0, off_s};
        grant_idx = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ))
                                                  : ID_W'(sum_s);
        req_any   = |req;
    end

    // Expand the winning index into the one-hot grant vector.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = req_any && (grant_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line between NUM_REQ byte producers.
// Frames are 8N1; defining UART_TX_PARITY_EN inserts an even parity bit (8E1).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_tick,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  tx
);

    uart_state_e            state_r;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [ID_W-1:0]        grant_id_r;
    logic [UART_DATA_W-1:0] shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   busy_r;
    logic                   tx_r;
`ifdef UART_TX_PARITY_EN
    logic                   parity_r;
`endif

    logic [NUM_REQ-1:0]     pick_onehot_s;
    logic [ID_W-1:0]        pick_idx_s;
    logic                   pick_any_s;
    logic [ID_W-1:0]        next_ptr_s;
    logic [UART_DATA_W-1:0] win_data_s;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (pick_onehot_s),
        .grant_idx (pick_idx_s),
        .req_any   (pick_any_s)
    );

    // Select the winner's byte and the pointer value that follows it.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data_s = win_data_s | (req_data[8*i +: 8] & {UART_DATA_W{pick_onehot_s[i]}});
        end
        next_ptr_s = (pick_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + ID_W'(1);
    end

    // Accept strobe: only in IDLE and never while reset is being applied.
    always_comb begin
        if (!reset && (state_r == ST_IDLE)) begin
            req_ready = pick_onehot_s;
        end else begin
            req_ready = '0;
        end
    end

    // Serializer FSM; every bit change follows a uart_tick so bit periods stay whole.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            shift_r    <= '0;
            bit_cnt_r  <= 3'd0;
            busy_r     <= 1'b0;
            tx_r       <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        shift_r    <= win_data_s;
                        grant_id_r <= pick_idx_s;
                        rr_ptr_r   <= next_ptr_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_ALIGN;
`ifdef UART_TX_PARITY_EN
                        parity_r   <= uart_even_parity(win_data_s);
`endif
                    end
                end
                ST_ALIGN: begin
                    if (uart_tick) begin
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (uart_tick) begin
                        tx_r      <= shift_r[0];
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (uart_tick) begin
                        shift_r   <= {1'b0, shift_r[UART_DATA_W-1:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= parity_r;
                            state_r <= ST_PARITY;
`else
                            tx_r    <= UART_IDLE_LVL;
                            state_r <= ST_STOP;
`endif
                        end else begin
                            tx_r <= shift_r[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (uart_tick) begin
                        tx_r    <= UART_IDLE_LVL;
                        state_r <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (uart_tick) begin
                        busy_r  <= 1'b0;
                        tx_r    <= UART_IDLE_LVL;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    tx_r    <= UART_IDLE_LVL;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id = grant_id_r;
    assign busy     = busy_r;
    assign tx       = tx_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a frame-level tick-counting model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          uart_tick = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic          tx;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .uart_tick (uart_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx        (tx)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a frame is the list of line levels after each tick following acceptance.
    bit   m_busy  = 1'b0;
    bit   m_tx    = 1'b1;
    int   m_ticks = 0;
    int   m_ptr   = 0;
    int   m_grant = 0;
    bit   m_frame[$];
    int   tick_period = 0;
    int   tick_cnt    = 0;
    int   last_accept = -1;
    logic [N-1:0] obs_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void make_frame(input logic [7:0] d);
        m_frame.delete();
        m_frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) m_frame.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        m_frame.push_back(^d);
`endif
        m_frame.push_back(1'b1);
    endfunction

    // One clock: drive the tick, check req_ready, advance the model, check registered outputs.
    task automatic step();
        int w;
        logic [N-1:0] exp_ready;
        uart_tick = (tick_period > 0) && (tick_cnt == 0);
        if (tick_period > 0) tick_cnt = (tick_cnt + 1) % tick_period;
        w = (!reset && !m_busy) ? pick(req_valid, m_ptr) : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        #1;
        obs_ready = req_ready;
        chk("req_ready", 32'(obs_ready), 32'(exp_ready));
        @(posedge clock);
        last_accept = w;
        if (reset) begin
            m_busy = 1'b0; m_tx = 1'b1; m_ptr = 0; m_grant = 0; m_ticks = 0;
        end else if (w >= 0) begin
            make_frame(req_data[8*w +: 8]);
            m_busy = 1'b1; m_ticks = 0; m_grant = w; m_ptr = (w + 1) % N;
        end else if (m_busy && uart_tick) begin
            m_ticks++;
            if (m_ticks <= NB) m_tx = m_frame[m_ticks-1];
            else begin m_busy = 1'b0; m_tx = 1'b1; end
        end
        @(negedge clock);
        chk("tx", 32'(tx), 32'(m_tx));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
    endtask

    task automatic reset_dut();
        reset = 1'b1; req_valid = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400 && m_busy; c++) step();
        chk("idle_reached", 32'(m_busy), 32'd0);
    endtask

    task automatic wait_accept(input int budget);
        int got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            step();
            if (obs_ready != '0) got = 1;
        end
        chk("accept_within_budget", 32'(got), 32'd1);
    endtask

    // Send one byte and check each captured line bit is exactly `per` cycles wide.
    task automatic send_capture(input int id, input logic [7:0] d, input int per,
                                input bit exp_bits[NB]);
        bit rec[$];
        int f;
        int got;
        tick_period = per; tick_cnt = 3;
        req_valid = '0; req_valid[id] = 1'b1; req_data[8*id +: 8] = d;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            step(); rec.push_back(tx);
            if (obs_ready != '0) got = 1;
        end
        chk("capture_accept", 32'(got), 32'd1);
        req_valid = '0;
        for (int c = 0; c < per * (NB + 3); c++) begin
            step(); rec.push_back(tx);
        end
        f = -1;
        for (int c = 0; c < rec.size(); c++) if (f < 0 && rec[c] == 1'b0) f = c;
        chk("start_bit_found", 32'(f >= 0), 32'd1);
        if (f >= 0) begin
            for (int k = 0; k < NB; k++) begin
                if (f + per * k + per - 1 < rec.size()) begin
                    chk("bit_first_cycle", 32'(rec[f + per*k]), 32'(exp_bits[k]));
                    chk("bit_last_cycle", 32'(rec[f + per*k + per - 1]), 32'(exp_bits[k]));
                end
            end
        end
        chk("capture_grant_id", 32'(grant_id), 32'(id));
    endtask

    initial begin
        int gl[$];
        int r2;
        bit exp_a5[NB];
`ifdef UART_TX_PARITY_EN
        bit exp_07[NB];
        bit exp_03[NB];
`endif
        // Model pins.
        chk("model_pick_wrap", 32'(pick(4'b0101, 3)), 32'd0);
        chk("model_pick_fwd", 32'(pick(4'b1001, 1)), 32'd3);

        // Reset idle: 100 cycles with ticks running and no requests.
        reset_dut();
        tick_period = 4;
        for (int c = 0; c < 100; c++) begin
            step();
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(req_ready), 32'd0);
        end

        // Single byte 0xA5 from requester 1, 16 cycles per bit.
`ifdef UART_TX_PARITY_EN
        exp_a5 = '{0, 1,0,1,0,0,1,0,1, 0, 1};
`else
        exp_a5 = '{0, 1,0,1,0,0,1,0,1, 1};
`endif
        send_capture(1, 8'hA5, 16, exp_a5);
        wait_idle();

        // Round-robin with all requesters continuously valid.
        reset_dut();
        tick_period = 2; tick_cnt = 0;
        req_data = 32'h13121110; req_valid = 4'hF;
        for (int c = 0; c < 600 && gl.size() < 5; c++) begin
            step();
            for (int i = 0; i < N; i++) if (obs_ready[i]) gl.push_back(i);
        end
        chk("rr_count", 32'(gl.size()), 32'd5);
        for (int k = 0; k < gl.size() && k < 5; k++) chk("rr_order", 32'(gl[k]), 32'(k % N));
        req_valid = '0;
        wait_idle();

        // Pointer wrap: move rr_ptr to 3, then offer requesters 0 and 2.
        reset_dut();
        tick_period = 2;
        req_valid = 4'b0100; req_data[23:16] = 8'h55;
        wait_accept(20);
        req_valid = '0;
        wait_idle();
        req_valid = 4'b0101; req_data[7:0] = 8'h5A;
        wait_accept(5);
        chk("wrap_ready", 32'(obs_ready), 32'h1);
        chk("wrap_grant_id", 32'(grant_id), 32'd0);

        // Withdrawal: requester 2 drops before acceptance and is never served.
        req_valid = 4'b1100; req_data[31:16] = 16'h3CC3;
        r2 = 0;
        for (int c = 0; c < 3; c++) begin step(); r2 += int'(obs_ready[2]); end
        req_valid = 4'b1000;
        for (int c = 0; c < 200 && obs_ready == '0; c++) begin step(); r2 += int'(obs_ready[2]); end
        chk("withdraw_winner", 32'(obs_ready), 32'h8);
        req_valid = '0;
        for (int c = 0; c < 400 && m_busy; c++) begin step(); r2 += int'(obs_ready[2]); end
        chk("withdraw_no_ready2", 32'(r2), 32'd0);

        // Reset in the middle of the data bits.
        reset_dut();
        tick_period = 2;
        req_valid = 4'b0010; req_data[15:8] = 8'h00;
        wait_accept(20);
        req_valid = '0;
        for (int c = 0; c < 100 && !(m_busy && m_ticks >= 4); c++) step();
        chk("reached_data", 32'(m_ticks >= 4), 32'd1);
        reset = 1'b1;
        step();
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        req_valid = 4'b0001;
        step();
        chk("midreset_idle_accept", 32'(obs_ready), 32'h1);
        req_valid = '0;
        wait_idle();

`ifdef UART_TX_PARITY_EN
        exp_07 = '{0, 1,1,1,0,0,0,0,0, 1, 1};
        exp_03 = '{0, 1,1,0,0,0,0,0,0, 0, 1};
        send_capture(2, 8'h07, 4, exp_07);
        wait_idle();
        send_capture(2, 8'h03, 4, exp_03);
        wait_idle();
`endif

        // Randomized traffic, tick rates, withdrawals and occasional resets.
        reset_dut();
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) begin
                tick_period = 1 + $urandom_range(0, 5);
                tick_cnt = 0;
            end
            reset = ($urandom_range(0, 999) == 0);
            for (int i = 0; i < N; i++) begin
                if (last_accept == i) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 79) == 0) req_valid[i] = 1'b0;
            end
            step();
        end
        reset = 1'b0; req_valid = '0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
